// File: rtl/draw_pkg.sv
// Shared definitions for the frame-draw sequencer: entity word layout,
// sequencer states and default widths.
package draw_pkg;

  localparam int unsigned PLOT_BIT = 33;
  localparam int unsigned SEL_HI   = 32;
  localparam int unsigned SEL_LO   = 30;
  localparam int unsigned Y_HI     = 25;
  localparam int unsigned Y_LO     = 16;
  localparam int unsigned X_HI     = 15;
  localparam int unsigned X_LO     = 6;
  localparam int unsigned DIR_HI   = 5;
  localparam int unsigned DIR_LO   = 0;

  localparam int unsigned DEF_ENTITY_SIZE = 34;
  localparam int unsigned DEF_COORD_W     = 10;
  localparam int unsigned DEF_COLOR_W     = 3;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    START,
    WAIT,
    NEXT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/draw_pixel_mux.sv
// Registered N-way pixel select: forwards the selected drawer's pixel to the
// VGA side one cycle later, only while enabled.
module draw_pixel_mux #(
  parameter int unsigned N       = 3,
  parameter int unsigned SEL_W   = 2,
  parameter int unsigned COORD_W = 10,
  parameter int unsigned COLOR_W = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [SEL_W-1:0]              sel,
  input  logic                          en,
  input  logic [N-1:0][COORD_W-1:0]     in_x,
  input  logic [N-1:0][COORD_W-1:0]     in_y,
  input  logic [N-1:0][COLOR_W-1:0]     in_color,
  input  logic [N-1:0]                  in_plot,
  output logic [COORD_W-1:0]            x,
  output logic [COORD_W-1:0]            y,
  output logic [COLOR_W-1:0]            color,
  output logic                          plot
);

  logic write_px;

  assign write_px = en & in_plot[sel];

  // Coordinates and colour only move on a real write so the VGA side sees
  // the last plotted pixel while plot is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x     <= '0;
      y     <= '0;
      color <= '0;
      plot  <= 1'b0;
    end else begin
      plot <= write_px;
      if (write_px) begin
        x     <= in_x[sel];
        y     <= in_y[sel];
        color <= in_color[sel];
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Frame-draw sequencer: snapshots the entity table on frame_start and walks
// every slot, handing visible entities to their class drawer in turn.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int unsigned ENTITY_SIZE   = DEF_ENTITY_SIZE,
  parameter int unsigned NUM_CLASSES   = 3,
  parameter int unsigned MAX_PER_CLASS = 10,
  parameter int unsigned COORD_W       = DEF_COORD_W,
  parameter int unsigned COLOR_W       = DEF_COLOR_W,
  parameter int unsigned TIMEOUT       = 4096
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              frame_start,
  input  logic [NUM_CLASSES-1:0][MAX_PER_CLASS-1:0][ENTITY_SIZE-1:0] entities,
  output logic [NUM_CLASSES-1:0]                            drw_start,
  output logic [ENTITY_SIZE-1:0]                            drw_entity,
  input  logic [NUM_CLASSES-1:0][COORD_W-1:0]               drw_x,
  input  logic [NUM_CLASSES-1:0][COORD_W-1:0]               drw_y,
  input  logic [NUM_CLASSES-1:0][COLOR_W-1:0]               drw_color,
  input  logic [NUM_CLASSES-1:0]                            drw_plot,
  input  logic [NUM_CLASSES-1:0]                            drw_done,
  output logic [COORD_W-1:0]                                x,
  output logic [COORD_W-1:0]                                y,
  output logic [COLOR_W-1:0]                                color,
  output logic                                              plot,
  output logic                                              busy,
  output logic                                              frame_done,
  output logic                                              frame_overrun,
  output logic                                              timeout_err
);

  localparam int unsigned IDX_W = (MAX_PER_CLASS > 1) ? $clog2(MAX_PER_CLASS) : 1;
  localparam int unsigned CLS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_PER_CLASS - 1);
  localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(NUM_CLASSES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  seq_state_t state, state_next;
  logic [NUM_CLASSES-1:0][MAX_PER_CLASS-1:0][ENTITY_SIZE-1:0] snap;
  logic [CLS_W-1:0] cls;
  logic [IDX_W-1:0] idx;
  logic [WD_W-1:0]  wd;

  // The snapshot and cls/idx are frozen from START through WAIT, so the
  // entity word is stable for the drawer without an extra register.
  assign drw_entity = snap[cls][idx];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      snap          <= '0;
      cls           <= '0;
      idx           <= '0;
      wd            <= '0;
      timeout_err   <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      state         <= state_next;
      frame_overrun <= frame_start && (state != IDLE);
      case (state)
        IDLE: if (frame_start) begin
          snap        <= entities;
          cls         <= '0;
          idx         <= '0;
          timeout_err <= 1'b0;
        end
        START: wd <= '0;
        WAIT: if (!drw_done[cls]) begin
          if (wd == WD_LAST) timeout_err <= 1'b1;
          if (wd != '1) wd <= wd + WD_W'(1);
        end
        NEXT: if (idx == IDX_LAST) begin
          idx <= '0;
          // Wrap to 0 after the last class so cls never indexes past the table.
          cls <= (cls == CLS_LAST) ? '0 : cls + CLS_W'(1);
        end else begin
          idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    drw_start  = '0;
    busy       = (state != IDLE);
    frame_done = 1'b0;
    case (state)
      IDLE:  if (frame_start) state_next = SCAN;
      SCAN:  state_next = snap[cls][idx][PLOT_BIT] ? START : NEXT;
      START: begin
        drw_start[cls] = 1'b1;
        state_next     = WAIT;
      end
      WAIT:  if (drw_done[cls] || (wd == WD_LAST)) state_next = NEXT;
      NEXT:  state_next = ((idx == IDX_LAST) && (cls == CLS_LAST)) ? DONE : SCAN;
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  draw_pixel_mux #(
    .N       (NUM_CLASSES),
    .SEL_W   (CLS_W),
    .COORD_W (COORD_W),
    .COLOR_W (COLOR_W)
  ) u_pixel_mux (
    .clk      (clk),
    .reset_n  (reset_n),
    .sel      (cls),
    .en       (state == WAIT),
    .in_x     (drw_x),
    .in_y     (drw_y),
    .in_color (drw_color),
    .in_plot  (drw_plot),
    .x        (x),
    .y        (y),
    .color    (color),
    .plot     (plot)
  );

endmodule

// File: tb/tb_draw_sequencer.sv
// Randomized self-checking bench for draw_sequencer against a slot-walk
// timing model built from per-slot cycle costs.
module tb_draw_sequencer;
  import draw_pkg::*;

  localparam int NC   = 3;
  localparam int MPC  = 3;
  localparam int TO   = 16;
  localparam int ES   = 34;
  localparam int CW   = 10;
  localparam int KW   = 3;
  localparam int MAXK = 512;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic frame_start = 1'b0;
  logic [NC-1:0][MPC-1:0][ES-1:0] entities = '0;
  logic [NC-1:0]          drw_start;
  logic [ES-1:0]          drw_entity;
  logic [NC-1:0][CW-1:0]  drw_x = '0;
  logic [NC-1:0][CW-1:0]  drw_y = '0;
  logic [NC-1:0][KW-1:0]  drw_color = '0;
  logic [NC-1:0]          drw_plot = '0;
  logic [NC-1:0]          drw_done = '0;
  logic [CW-1:0]          x, y;
  logic [KW-1:0]          color;
  logic                   plot, busy, frame_done, frame_overrun, timeout_err;

  always #5 clk = ~clk;

  draw_sequencer #(
    .ENTITY_SIZE   (ES),
    .NUM_CLASSES   (NC),
    .MAX_PER_CLASS (MPC),
    .COORD_W       (CW),
    .COLOR_W       (KW),
    .TIMEOUT       (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .frame_start   (frame_start),
    .entities      (entities),
    .drw_start     (drw_start),
    .drw_entity    (drw_entity),
    .drw_x         (drw_x),
    .drw_y         (drw_y),
    .drw_color     (drw_color),
    .drw_plot      (drw_plot),
    .drw_done      (drw_done),
    .x             (x),
    .y             (y),
    .color         (color),
    .plot          (plot),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_overrun (frame_overrun),
    .timeout_err   (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [NC-1:0][MPC-1:0][ES-1:0] snap_m;
  int            dly[NC];          // drawer done delay after start; 0 = never
  int            st_cls[MAXK];
  int            win_cls[MAXK];
  int            done_cls[MAXK];
  bit            terr_set[MAXK];
  logic [ES-1:0] act_word[MAXK];
  bit            exp_plot = 1'b0;
  logic [CW-1:0] exp_x = '0, exp_y = '0;
  logic [KW-1:0] exp_col = '0;
  bit            exp_terr = 1'b0;

  function automatic logic [ES-1:0] make_entity(input bit vis, input logic [2:0] sel,
                                                input logic [CW-1:0] ex, input logic [CW-1:0] ey,
                                                input logic [5:0] dir);
    logic [ES-1:0] e;
    e = '0;
    e[PLOT_BIT]      = vis;
    e[SEL_HI:SEL_LO] = sel;
    e[Y_HI:Y_LO]     = ey;
    e[X_HI:X_LO]     = ex;
    e[DIR_HI:DIR_LO] = dir;
    return e;
  endfunction

  task automatic rand_table(input int vis_pct);
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < MPC; i++)
        entities[c][i] = make_entity($urandom_range(99) < vis_pct, 3'($urandom), CW'($urandom),
                                     CW'($urandom), 6'($urandom));
  endtask

  // Cycle k=0 drives frame_start; an invisible slot costs SCAN+NEXT, a visible
  // one SCAN+START+NEXT plus its WAIT length, and the frame ends in DONE.
  task automatic run_frame(input bit scramble, input int ovr_pct, input int rst_k, input bit fixed_pix);
    int t, s, w, done_k, obs_done, k_end, c;
    logic [NC-1:0] exp_st;
    bit ovr_exp;
    for (int k = 0; k < MAXK; k++) begin
      st_cls[k] = -1; win_cls[k] = -1; done_cls[k] = -1; terr_set[k] = 1'b0; act_word[k] = '0;
    end
    snap_m = entities;
    t = 1;
    for (int ci = 0; ci < NC; ci++) begin
      for (int i = 0; i < MPC; i++) begin
        if (!snap_m[ci][i][PLOT_BIT]) begin
          t += 2;
        end else begin
          s = t + 1;
          w = (dly[ci] == 0) ? TO : dly[ci];
          st_cls[s] = ci;
          act_word[s] = snap_m[ci][i];
          for (int j = 1; j <= w; j++) begin
            win_cls[s+j] = ci;
            act_word[s+j] = snap_m[ci][i];
          end
          if (dly[ci] == 0) terr_set[s+w+1] = 1'b1;
          else done_cls[s+dly[ci]] = ci;
          t += 3 + w;
        end
      end
    end
    done_k = t;
    obs_done = -1;
    ovr_exp = 1'b0;
    k_end = (rst_k >= 0) ? rst_k + 2 : done_k + 1;
    for (int k = 0; k <= k_end; k++) begin
      @(negedge clk);
      if (rst_k >= 0 && k == rst_k + 2) begin
        exp_plot = 1'b0; exp_x = '0; exp_y = '0; exp_col = '0; exp_terr = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_plot", plot, 0);
        check_eq("rst_drw_start", drw_start, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_timeout_err", timeout_err, 0);
        check_eq("rst_drw_entity", drw_entity, 0);
        check_eq("rst_x", x, 0);
      end else if (!(rst_k >= 0 && k == rst_k + 1)) begin
        if (k == 1) exp_terr = 1'b0;
        if (terr_set[k]) exp_terr = 1'b1;
        exp_st = '0;
        if (st_cls[k] >= 0) exp_st[st_cls[k]] = 1'b1;
        check_eq("busy", busy, (k >= 1 && k <= done_k));
        check_eq("frame_done", frame_done, (k == done_k));
        check_eq("drw_start", drw_start, exp_st);
        if (st_cls[k] >= 0 || win_cls[k] >= 0) check_eq("drw_entity", drw_entity, act_word[k]);
        check_eq("plot", plot, exp_plot);
        check_eq("x", x, exp_x);
        check_eq("y", y, exp_y);
        check_eq("color", color, exp_col);
        check_eq("timeout_err", timeout_err, exp_terr);
        check_eq("frame_overrun", frame_overrun, ovr_exp);
      end
      if (frame_done === 1'b1 && obs_done < 0) obs_done = k;

      reset_n = !(rst_k >= 0 && (k == rst_k || k == rst_k + 1));
      frame_start = (k == 0) || (rst_k < 0 && k >= 1 && k <= done_k && $urandom_range(99) < ovr_pct);
      ovr_exp = frame_start && (k >= 1);
      if (scramble && k >= 1) rand_table(50);
      for (int ci = 0; ci < NC; ci++) begin
        drw_x[ci]     = CW'($urandom);
        drw_y[ci]     = CW'($urandom);
        drw_color[ci] = KW'($urandom);
        drw_plot[ci]  = $urandom_range(1);
        drw_done[ci]  = (ci != win_cls[k]) && ($urandom_range(3) == 0);
      end
      if (done_cls[k] >= 0) drw_done[done_cls[k]] = 1'b1;
      c = win_cls[k];
      if (c >= 0 && fixed_pix) begin
        drw_x[c] = CW'(50); drw_y[c] = '0; drw_color[c] = 3'b111; drw_plot[c] = 1'b1;
      end
      if (c >= 0) begin
        exp_plot = drw_plot[c];
        if (drw_plot[c]) begin
          exp_x = drw_x[c]; exp_y = drw_y[c]; exp_col = drw_color[c];
        end
      end else begin
        exp_plot = 1'b0;
      end
    end
    frame_start = 1'b0;
    reset_n = 1'b1;
    drw_done = '0;
    if (rst_k < 0) check_eq("done_latency", obs_done, done_k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    dly = '{5, 5, 5};
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("init_busy", busy, 0);
    check_eq("init_plot", plot, 0);
    check_eq("init_drw_start", drw_start, 0);
    check_eq("init_frame_done", frame_done, 0);
    check_eq("init_overrun", frame_overrun, 0);
    check_eq("init_timeout_err", timeout_err, 0);
    check_eq("init_drw_entity", drw_entity, 0);
    check_eq("init_xyc", {x, y, color}, 0);
    reset_n = 1'b1;

    // Only asteroid[1] and ship[0] visible
    entities = '0;
    entities[1][1] = make_entity(1'b1, 3'd1, CW'(102), CW'(102), 6'd5);
    entities[2][0] = make_entity(1'b1, 3'd2, CW'(320), CW'(240), 6'd0);
    run_frame(1'b0, 0, -1, 1'b0);

    // Empty frame
    entities = '0;
    run_frame(1'b0, 0, -1, 1'b0);

    // Drawer 1 hangs; later slots must still be drawn
    entities = '0;
    entities[0][0] = make_entity(1'b1, 3'd0, CW'(10), CW'(20), 6'd1);
    entities[1][1] = make_entity(1'b1, 3'd1, CW'(30), CW'(40), 6'd2);
    entities[2][2] = make_entity(1'b1, 3'd2, CW'(50), CW'(60), 6'd3);
    dly = '{3, 0, 4};
    run_frame(1'b0, 0, -1, 1'b0);

    // Done exactly at watchdog expiry counts as done
    dly = '{TO, TO, TO};
    run_frame(1'b0, 0, -1, 1'b0);

    // Overruns and mid-frame table changes
    rand_table(60);
    dly = '{2, 6, 3};
    run_frame(1'b1, 25, -1, 1'b0);

    // Fixed pixel from the active drawer
    entities = '0;
    entities[0][2] = make_entity(1'b1, 3'd0, CW'(1), CW'(2), 6'd0);
    dly = '{8, 8, 8};
    run_frame(1'b0, 0, -1, 1'b1);

    // Reset mid-WAIT on class 1, then a normal frame
    entities = '0;
    entities[1][0] = make_entity(1'b1, 3'd1, CW'(7), CW'(9), 6'd4);
    dly = '{5, 0, 5};
    run_frame(1'b0, 0, 12, 1'b0);
    dly = '{5, 5, 5};
    run_frame(1'b0, 0, -1, 1'b0);

    for (int n = 0; n < 25; n++) begin
      rand_table(35);
      for (int c = 0; c < NC; c++)
        dly[c] = ($urandom_range(4) == 0) ? 0 : int'($urandom_range(TO, 1));
      run_frame($urandom_range(1), 10, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
